bram_dp_clr: RTL
================

Name: bram_dp_clr

Overview:
- Parametrised dual-port synchronous block RAM with two ports: port A is read/write, port B is read-only.
- Adds features for data memory, VRAM and palette use: byte-lane write enables, read latency of 1 or 2, a selectable read-during-write mode on port A, per-port read-valid flags, and a sequential clear engine.
- The clear engine sweeps every word to CLR_VALUE after reset or on request.

Parameters:
- DATA_W, 32: word width; must be a multiple of 8.
- ADDR_W, 12: address width; DEPTH = 2**ADDR_W.
- RD_LAT, 1: read latency in cycles; legal values 1 or 2. With 2, an extra output register is added on both ports.
- WR_MODE, 0: port A read-during-write. 0 = read-first (old data), 1 = write-first (new merged data).
- CLR_ON_RESET, 1: 1 = start a clear sweep automatically when reset is released.
- CLR_VALUE, 0: DATA_W-bit value written by the clear sweep.

Ports:
- clka, in, 1: clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- ena, in, 1: port A access request.
- wea, in, DATA_W/8: byte write enables; bit i covers dina[8i+7:8i]. A cycle is a write if any bit is set, otherwise a read.
- addra, in, ADDR_W: port A word address.
- dina, in, DATA_W: port A write data.
- douta, out, DATA_W: port A read data.
- valida, out, 1: douta holds the result of an accepted port A access.
- enb, in, 1: port B read request.
- addrb, in, ADDR_W: port B word address.
- doutb, out, DATA_W: port B read data.
- validb, out, 1: doutb holds the result of an accepted port B read.
- clr_req, in, 1: single-cycle pulse that starts a clear sweep.
- busy, out, 1: clear sweep in progress.

Behaviour:
- Reset (async, rst_n=0):
  - douta, doutb, valida, validb = 0; clear counter = 0; pipeline registers = 0.
  - state = CLEAR and busy = 1 if CLR_ON_RESET=1, otherwise state = IDLE and busy = 0.
  - Array contents are not reset.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req=1: counter = 0, busy = 1 from the next cycle.
  - In CLEAR, each cycle writes CLR_VALUE to address `counter`, then increments the counter.
  - The write to address DEPTH-1 happens in the last CLEAR cycle; the next state is IDLE, with busy = 0 in the cycle after that write.
  - A sweep takes exactly DEPTH cycles. clr_req is ignored while in CLEAR.
- Reset asserted mid-sweep: contents are left partially cleared. On release, the sweep restarts from address 0 if CLR_ON_RESET=1, otherwise the FSM goes to IDLE.
- Port A accept condition: ena=1 and busy=0.
  - While busy, port A accesses are dropped: no write, no valid.
  - An accepted write updates only the enabled bytes.
- Port A read data is sampled on the accept edge:
  - WR_MODE=0: the pre-write word.
  - WR_MODE=1: the word after the byte merge.
  - A write also produces douta and valida.
- Latency:
  - douta and valida update RD_LAT cycles after the accept edge.
  - valida = 0 in cycles with no accepted access; douta holds its last value.
- Port B:
  - enb is accepted in all states, including CLEAR.
  - doutb and validb follow the same latency rule as port A.
  - Same-address collision with a port A or clear write in the same cycle: port B returns the old data (read-first, fixed).
- Port A and port B may use the same or different addresses in the same cycle without interaction, apart from the collision rule above.
- busy reflects the registered FSM state; it is not a combinational function of clr_req.

Test Plan:
1. CLR_ON_RESET=1, ADDR_W=4: release rst_n, then hold ena=1 → busy=1 for exactly 16 cycles and no valida during them. Then read addr 7 → douta=0x00000000 with valida 1 cycle later (RD_LAT=1).
2. Write 0xAABBCCDD to addr 3 with wea=1111, then write 0x11223344 to addr 3 with wea=0101, then read addr 3 → douta=0xAA22CC44.
3. WR_MODE=0 vs WR_MODE=1: addr 5 holds 0x1, write 0x2 to addr 5 with wea=1111 → douta=0x1 (WR_MODE=0) or 0x2 (WR_MODE=1). Same cycle, enb=1 with addrb=5 → doutb=0x1 in both modes.
4. RD_LAT=2: back-to-back port B reads of addrs 0,1,2 holding 10,11,12 → doutb=10,11,12 on cycles 2,3,4 after the first accept; validb is high for exactly 3 consecutive cycles.
5. Pulse clr_req with CLR_VALUE=0xDEADBEEF; write addr 2 during busy; then read addr 2 → the write is ignored and douta=0xDEADBEEF. A second clr_req pulse mid-sweep does not extend busy beyond DEPTH cycles.
6. Assert rst_n=0 at counter=5 of a sweep: outputs go to 0 asynchronously. Release with CLR_ON_RESET=1 → busy stays 1 for a full DEPTH cycles and the sweep restarts at address 0.

Source files
------------

// File: rtl/bram_dp_clr.sv
// Dual-port block RAM with a read/write port A and a read-only port B.
// Adds byte-lane writes, 1- or 2-cycle read latency and a sequential clear engine.
module bram_dp_clr #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 12,
    parameter int                RD_LAT       = 1,
    parameter int                WR_MODE      = 0,
    parameter int                CLR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLR_VALUE    = '0
) (
    input  logic                clka,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    output logic [DATA_W-1:0]   douta,
    output logic                valida,
    input  logic                enb,
    input  logic [ADDR_W-1:0]   addrb,
    output logic [DATA_W-1:0]   doutb,
    output logic                validb,
    input  logic                clr_req,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam state_t RST_STATE = (CLR_ON_RESET != 0) ? CLEAR : IDLE;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;

    logic              acc_a;
    logic              wr_a;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_a_word;

    logic [DATA_W-1:0] douta_q;
    logic [DATA_W-1:0] doutb_q;
    logic              valida_q;
    logic              validb_q;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // The sweep ends after writing the all-ones address, so a full pass is DEPTH cycles.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (&clr_cnt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == CLEAR);
    assign acc_a = ena & ~busy;
    assign wr_a  = acc_a & (|wea);

    always_comb begin
        merged = mem[addra];
        for (int i = 0; i < NB; i++) begin
            if (wea[i]) begin
                merged[8*i +: 8] = dina[8*i +: 8];
            end
        end
    end

    assign rd_a_word = (WR_MODE != 0) ? merged : mem[addra];

    // Clear and port A writes are mutually exclusive because port A is blocked while busy.
    always_ff @(posedge clka) begin
        if (busy && rst_n) begin
            mem[clr_cnt] <= CLR_VALUE;
        end else if (wr_a) begin
            mem[addra] <= merged;
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            douta_q  <= '0;
            doutb_q  <= '0;
            valida_q <= 1'b0;
            validb_q <= 1'b0;
        end else begin
            valida_q <= acc_a;
            validb_q <= enb;
            if (acc_a) begin
                douta_q <= rd_a_word;
            end
            if (enb) begin
                doutb_q <= mem[addrb];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] douta_q2;
            logic [DATA_W-1:0] doutb_q2;
            logic              valida_q2;
            logic              validb_q2;

            always_ff @(posedge clka or negedge rst_n) begin
                if (!rst_n) begin
                    douta_q2  <= '0;
                    doutb_q2  <= '0;
                    valida_q2 <= 1'b0;
                    validb_q2 <= 1'b0;
                end else begin
                    valida_q2 <= valida_q;
                    validb_q2 <= validb_q;
                    if (valida_q) begin
                        douta_q2 <= douta_q;
                    end
                    if (validb_q) begin
                        doutb_q2 <= doutb_q;
                    end
                end
            end

            assign douta  = douta_q2;
            assign doutb  = doutb_q2;
            assign valida = valida_q2;
            assign validb = validb_q2;
        end else begin : g_lat1
            assign douta  = douta_q;
            assign doutb  = doutb_q;
            assign valida = valida_q;
            assign validb = validb_q;
        end
    endgenerate

endmodule
